keyboard_event_queue: RTL and testbench
=======================================

# keyboard_event_queue

Converts the raw PS/2 scan-code byte stream into discrete key events and queues them for the READKEY instruction path. It sits between the PS/2 byte receiver and the keyboard reader. It decodes the E0 (extended) and F0 (break) prefixes, buffers decoded events in a small FIFO, and presents the head event as `key_status`/`keycode`. An event is popped when the reader consumes it, so no keystroke is lost between READKEY instructions.

## Interface
- `DEPTH_LOG2`, default 3: FIFO depth is 2^DEPTH_LOG2 events (default 8).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a newly received PS/2 byte.
- `rx_data`  in  8  received scan-code byte.
- `consume`  in  1  asserted by the reader on the cycle it latches the head event (READKEY executed with `key_status[1]`=1).
- `key_status`  out  8  bit 0 = is_break; bit 1 = event valid (new input); bit 2 = extended (E0); bit 3 = overflow (sticky); bits 7:4 = 0.
- `keycode`  out  8  scan code of the head event; 0x00 when the queue is empty.

## Operation
- Prefix decoder FSM, evaluated only on cycles with `rx_valid`=1:
  - IDLE: E0 → EXT; F0 → BRK; other → push {ext=0, brk=0, code}.
  - EXT: F0 → EXT_BRK; E0 → stay in EXT; other → push {ext=1, brk=0, code} and go to IDLE.
  - BRK: E0 or F0 → stay in BRK (tolerated); other → push {ext=0, brk=1, code} and go to IDLE.
  - EXT_BRK: E0 or F0 → stay in EXT_BRK; other → push {ext=1, brk=1, code} and go to IDLE.
- Filtered bytes are 0x00, 0xFF, 0xAA, 0xFA, 0xFE and 0xEE. In any state, a filtered byte causes no push and forces the FSM to IDLE, discarding any pending prefix.
- 0xE1 and every other byte are ordinary codes.
- FIFO:
  - Each entry is 10 bits: {ext, brk, code}. The FIFO uses register storage with wrapping read/write pointers (DEPTH_LOG2 bits) and a count (DEPTH_LOG2+1 bits).
  - Push when full: the entry is dropped, `key_status[3]` is set, and the FSM still returns to IDLE.
  - Pop occurs when `consume`=1 and the queue is non-empty. `consume` while empty is ignored.
  - Push and pop in the same cycle while full: both succeed, count is unchanged, and overflow is not set.
  - Push and `consume` in the same cycle while empty: the push succeeds and the `consume` is ignored.
- Overflow clears only on a pop that leaves the queue empty, or on reset.
- Outputs are driven from registers only:
  - `key_status[1]` = (count≠0).
  - `key_status[0]` and `key_status[2]` come from the head entry and are 0 when empty.
  - `key_status[3]` = overflow flag.
  - `keycode` = head code, or 0x00 when empty.

## Timing
- Reset (asynchronous, takes effect immediately): FSM=IDLE, pointers=0, count=0, overflow=0, `key_status`=0x00, `keycode`=0x00.
- Latency: a final byte accepted on edge N is visible on the outputs after edge N (one cycle). A prefix byte produces no output change.
- Pop: with `consume` sampled at edge N, the next entry (or the empty state) is presented after edge N. The reader latches the old head on that same edge.
- Pointers wrap modulo 2^DEPTH_LOG2. Count never exceeds 2^DEPTH_LOG2.
- `rx_valid` may arrive every cycle; there is no backpressure to the receiver.
- Reset asserted mid-prefix or with a non-empty queue discards everything; the first byte after reset is decoded from IDLE.

## Test plan
- Make code: after reset, send 0x1C → one cycle later `key_status`=0x02 and `keycode`=0x1C. Pulse `consume` → `key_status`=0x00, `keycode`=0x00.
- Extended break: send E0, F0, 0x75 → a single event with `key_status`=0x07 and `keycode`=0x75. Prefix bytes alone leave `key_status`=0x00.
- Overflow: send 9 make codes 0x01..0x09 with no `consume` → head is 0x01 and `key_status`=0x0A.
  - Consume 7 times → head is 0x08 and bit 3 is still set.
  - Consume once more → `key_status`=0x00.
- Simultaneous: with the queue full, push 0x10 and `consume` in the same cycle → count stays 8, head advances, overflow stays 0. With the queue empty, push 0x11 and `consume` in the same cycle → 0x11 is queued.
- Filter and reset: send F0 then 0xAA → no event and FSM in IDLE; then 0x1C → make event (brk=0). Assert `rst` mid-sequence (E0 pending, 3 events queued) → all outputs 0x00 immediately; then send 0x1C → non-extended make.

Source files
------------

// File: rtl/keyboard_event_queue.sv
// PS/2 scan-code prefix decoder (E0/F0) feeding a small event FIFO.
// The head event is presented on key_status/keycode until the reader consumes it.
module keyboard_event_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       consume,
  output logic [7:0] key_status,
  output logic [7:0] keycode
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kev_t;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t                state, state_nxt;
  logic                  push_req, push_ok, pop, full, filt;
  kev_t                  push_ev, head;
  kev_t                  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  ovf;

  // Bus-protocol bytes (ack, resend, echo, BAT, errors) are not keystrokes
  always_comb begin
    filt = 1'b0;
    case (rx_data)
      8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE: filt = 1'b1;
      default: filt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    push_ev   = '{ext: 1'b0, brk: 1'b0, code: rx_data};
    if (rx_valid) begin
      if (filt) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rx_data == 8'hE0)      state_nxt = EXT;
            else if (rx_data == 8'hF0) state_nxt = BRK;
            else                       push_req  = 1'b1;
          end
          EXT: begin
            if (rx_data == 8'hF0)      state_nxt = EXT_BRK;
            else if (rx_data != 8'hE0) begin
              push_req    = 1'b1;
              push_ev.ext = 1'b1;
              state_nxt   = IDLE;
            end
          end
          BRK: begin
            if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
              push_req    = 1'b1;
              push_ev.brk = 1'b1;
              state_nxt   = IDLE;
            end
          end
          EXT_BRK: begin
            if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
              push_req    = 1'b1;
              push_ev.ext = 1'b1;
              push_ev.brk = 1'b1;
              state_nxt   = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full queue still lands
  assign full    = (count == DEPTH_C);
  assign pop     = consume && (count != '0);
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_ev;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Overflow stays visible until the backlog is fully drained
      if (push_req && !push_ok)
        ovf <= 1'b1;
      else if (pop && !push_ok && count == (DEPTH_LOG2+1)'(1))
        ovf <= 1'b0;
    end
  end

  always_comb begin
    head       = mem[rd_ptr];
    key_status = 8'h00;
    keycode    = 8'h00;
    key_status[3] = ovf;
    if (count != '0) begin
      key_status[0] = head.brk;
      key_status[1] = 1'b1;
      key_status[2] = head.ext;
      keycode       = head.code;
    end
  end
endmodule

// File: tb/tb_keyboard_event_queue.sv
// Scoreboard bench for keyboard_event_queue: a behavioural decoder/queue model
// predicts the head event after every cycle.
module tb_keyboard_event_queue;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       consume = 1'b0;
  logic [7:0] key_status;
  logic [7:0] keycode;

  keyboard_event_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .consume(consume), .key_status(key_status), .keycode(keycode)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: {ext, brk, code} entries expected at the DUT head, oldest first
  logic [9:0] sb [$];
  int         m_st  = 0;  // 0 idle, 1 ext, 2 brk, 3 ext+brk
  logic       m_ovf = 1'b0;
  logic [7:0] filt_tab [6] = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic is_filt(input logic [7:0] b);
    for (int i = 0; i < 6; i++) if (filt_tab[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_out(input string tag);
    logic [7:0] exp_st, exp_kc;
    exp_st = {4'b0, m_ovf, 3'b000};
    exp_kc = 8'h00;
    if (sb.size() != 0) begin
      exp_st[2] = sb[0][9];
      exp_st[1] = 1'b1;
      exp_st[0] = sb[0][8];
      exp_kc    = sb[0][7:0];
    end
    chk({tag, ".status"}, key_status, exp_st);
    chk({tag, ".code"},   keycode,    exp_kc);
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare
  task automatic step(input logic v, input logic [7:0] d, input logic c, input string tag);
    logic       push, pop_ok, push_ok;
    logic [9:0] ev;
    rx_valid = v; rx_data = d; consume = c;
    push = 1'b0;
    ev   = {2'b00, d};
    if (v) begin
      if (is_filt(d)) m_st = 0;
      else if (d == 8'hE0) begin
        if (m_st == 0) m_st = 1;
        else if (m_st == 2) m_st = 2;
      end else if (d == 8'hF0) begin
        if (m_st == 0) m_st = 2;
        else if (m_st == 1) m_st = 3;
      end else begin
        push  = 1'b1;
        ev[9] = (m_st == 1 || m_st == 3);
        ev[8] = (m_st == 2 || m_st == 3);
        m_st  = 0;
      end
    end
    pop_ok  = c && sb.size() != 0;
    push_ok = push && (sb.size() < DEPTH || pop_ok);
    @(posedge clk);
    if (pop_ok) void'(sb.pop_front());
    if (push_ok) sb.push_back(ev);
    else if (push) m_ovf = 1'b1;
    if (pop_ok && sb.size() == 0) m_ovf = 1'b0;
    #1;
    rx_valid = 1'b0; consume = 1'b0;
    check_out(tag);
  endtask

  task automatic model_reset();
    sb.delete();
    m_st  = 0;
    m_ovf = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_held");
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, "reset_idle");

    // Make code then consume
    step(1'b1, 8'h1C, 1'b0, "make");
    step(1'b0, 8'h00, 1'b1, "make_pop");

    // Extended break: prefixes alone leave outputs idle
    step(1'b1, 8'hE0, 1'b0, "xb_e0");
    step(1'b1, 8'hF0, 1'b0, "xb_f0");
    step(1'b1, 8'h75, 1'b0, "xb_code");
    step(1'b0, 8'h00, 1'b1, "xb_pop");

    // Overflow: 9 makes into 8 slots, drain with sticky flag
    for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), 1'b0, "ovf_fill");
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, "ovf_drain");
    step(1'b0, 8'h00, 1'b1, "ovf_empty");

    // Push+pop while full, then push+consume while empty
    for (int i = 0; i < 8; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, "sim_fill");
    step(1'b1, 8'h10, 1'b1, "sim_full");
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, "sim_drain");
    step(1'b1, 8'h11, 1'b1, "sim_empty");
    step(1'b0, 8'h00, 1'b1, "sim_pop");

    // Filtered byte cancels a pending break prefix
    step(1'b1, 8'hF0, 1'b0, "filt_f0");
    step(1'b1, 8'hAA, 1'b0, "filt_aa");
    step(1'b1, 8'h1C, 1'b0, "filt_make");
    step(1'b0, 8'h00, 1'b1, "filt_pop");

    // Asynchronous reset with E0 pending and 3 events queued
    step(1'b1, 8'h15, 1'b0, "rst_q1");
    step(1'b1, 8'h16, 1'b0, "rst_q2");
    step(1'b1, 8'h17, 1'b0, "rst_q3");
    step(1'b1, 8'hE0, 1'b0, "rst_e0");
    #2 rst = 1'b1;
    model_reset();
    #1 check_out("rst_async");
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 8'h1C, 1'b0, "rst_make");
    step(1'b0, 8'h00, 1'b1, "rst_pop");

    // Random mix of prefixes, filtered bytes, codes and consumes
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 8'hE0;
      else if (sel == 1) b = 8'hF0;
      else if (sel == 2) b = filt_tab[$urandom_range(0, 5)];
      else               b = 8'($urandom_range(1, 127));
      step(($urandom_range(0, 3) != 0), b, ($urandom_range(0, 2) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
